// File: rtl/parity_pkg.sv
// Shared definitions for the streaming parity generator/checker:
// frame FSM state encoding and parity mode constants.
package parity_pkg;

   // Frame tracking state: IDLE waits for the first word of a frame,
   // IN_FRAME means at least one non-last word of the frame was accepted.
   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_IN_FRAME = 1'b1
   } state_t;

   // Parity mode values as driven on odd_sel and held in the latched mode.
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage : parity_pkg

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of a data word: p = 1 when the word holds
// an odd number of ones.
module parity_reduce #(
   parameter int DATA_W = 9
) (
   input  logic [DATA_W-1:0] in_data,
   output logic              p
);

   // Plain reduction; kept in its own module so the width is set in one place.
   always_comb begin
      p = ^in_data;
   end

endmodule : parity_reduce

// File: rtl/parity_stream_gen_chk.sv
// Streaming parity generator/checker. One output register stage behind a
// valid/ready handshake; adds per-word parity, per-frame parity and an
// optional check of a received parity bit with a saturating error count.
module parity_stream_gen_chk
   import parity_pkg::*;
#(
   parameter int DATA_W = 9,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   input  logic              in_last,
   input  logic              odd_sel,
   input  logic              chk_en,
   input  logic              err_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_par,
   output logic              out_last,
   output logic              out_frame_par,
   output logic              out_word_err,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t state;
   state_t state_next;

   logic mode;         // parity mode latched at frame start
   logic acc;          // running XOR of word parities of the current frame
   logic p;            // raw parity of the incoming word
   logic accept;
   logic mode_used;    // mode applying to the incoming word
   logic acc_used;     // accumulator as seen by the incoming word
   logic gen_par;
   logic word_err;
   logic err_hit;

   parity_reduce #(
      .DATA_W (DATA_W)
   ) u_reduce (
      .in_data (in_data),
      .p       (p)
   );

   // Handshake and per-word parity terms. A word starting a frame uses
   // odd_sel directly and sees a cleared accumulator, so a stale acc can
   // never leak into a new frame.
   always_comb begin
      in_ready  = ~out_valid | out_ready;
      accept    = in_valid & in_ready;
      mode_used = (state == ST_IDLE) ? odd_sel : mode;
      acc_used  = (state == ST_IDLE) ? 1'b0 : acc;
      gen_par   = p ^ mode_used;
      word_err  = chk_en & (in_par != gen_par);
      err_hit   = accept & word_err;
   end

   // Frame FSM next-state: only accepted words move it.
   always_comb begin
      state_next = state;
      if (accept) begin
         if (in_last) begin
            state_next = ST_IDLE;
         end else begin
            state_next = ST_IN_FRAME;
         end
      end
   end

   // Frame FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Frame mode latch and running parity accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode <= PAR_EVEN;
         acc  <= 1'b0;
      end else if (accept) begin
         if (state == ST_IDLE) begin
            mode <= odd_sel;
         end
         if (in_last) begin
            acc <= 1'b0;
         end else begin
            acc <= acc_used ^ p;
         end
      end
   end

   // Output register: loaded on accept, emptied when drained without refill,
   // held while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_par       <= 1'b0;
         out_last      <= 1'b0;
         out_frame_par <= 1'b0;
         out_word_err  <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         out_data      <= in_data;
         out_par       <= gen_par;
         out_last      <= in_last;
         out_frame_par <= in_last ? (acc_used ^ p ^ mode_used) : 1'b0;
         out_word_err  <= word_err;
      end else if (out_ready) begin
         out_valid     <= 1'b0;
      end
   end

   // Saturating mismatch counter; a clear coinciding with an erroring
   // word leaves a count of one so that error is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= err_hit ? CNT_ONE : '0;
      end else if (err_hit && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + CNT_ONE;
      end
   end

endmodule : parity_stream_gen_chk

// File: tb/tb_parity_stream_gen_chk.sv
// Self-checking bench for parity_stream_gen_chk: directed scenarios plus a
// randomized run against a frame-level reference model. A second instance
// with a 2-bit counter shares all inputs to exercise saturation.
module tb_parity_stream_gen_chk;

   localparam int DW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_par = 1'b0;
   logic          in_last = 1'b0;
   logic          odd_sel = 1'b0;
   logic          chk_en = 1'b0;
   logic          err_clr = 1'b0;
   logic          out_ready = 1'b1;

   logic          in_ready, out_valid, out_par, out_last, out_frame_par, out_word_err;
   logic [DW-1:0] out_data;
   logic [7:0]    err_cnt;

   logic          in_ready2, out_valid2, out_par2, out_last2, out_frame_par2, out_word_err2;
   logic [DW-1:0] out_data2;
   logic [1:0]    err_cnt2;

   int checks = 0;
   int fails  = 0;

   // reference model state
   bit            m_valid, m_par, m_last, m_fpar, m_werr, m_in_frame, m_mode;
   logic [DW-1:0] m_data;
   int            m_err, m_err2, m_ones;
   bit            m_rdy;
   logic          obs_ready;

   always #5 clk = ~clk;

   parity_stream_gen_chk #(.DATA_W(DW), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_par(in_par), .in_last(in_last), .odd_sel(odd_sel),
      .chk_en(chk_en), .err_clr(err_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_par(out_par), .out_last(out_last),
      .out_frame_par(out_frame_par), .out_word_err(out_word_err), .err_cnt(err_cnt)
   );

   parity_stream_gen_chk #(.DATA_W(DW), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .in_par(in_par), .in_last(in_last), .odd_sel(odd_sel),
      .chk_en(chk_en), .err_clr(err_clr), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .out_par(out_par2), .out_last(out_last2),
      .out_frame_par(out_frame_par2), .out_word_err(out_word_err2), .err_cnt(err_cnt2)
   );

   task automatic model_reset();
      m_valid = 0; m_data = '0; m_par = 0; m_last = 0; m_fpar = 0; m_werr = 0;
      m_in_frame = 0; m_mode = 0; m_err = 0; m_err2 = 0; m_ones = 0;
   endtask

   // Parity that makes the word's ones count even (mode 0) or odd (mode 1).
   function automatic bit want_par(input logic [DW-1:0] d, input bit mode);
      return bit'(($countones(d) + (mode ? 1 : 0)) % 2);
   endfunction

   // Drive one cycle of inputs, advance the model at the clock edge and
   // leave time at posedge+1 for the caller's comparisons.
   task automatic step(input bit v, input logic [DW-1:0] d, input bit par,
                       input bit last, input bit odd, input bit chk,
                       input bit clr, input bit ordy);
      bit acc_ok, mode_w, g, werr;
      in_valid = v; in_data = d; in_par = par; in_last = last;
      odd_sel = odd; chk_en = chk; err_clr = clr; out_ready = ordy;
      #1;
      obs_ready = in_ready;
      m_rdy  = !m_valid || ordy;
      acc_ok = v && m_rdy;
      @(posedge clk);
      #1;
      werr = 0;
      if (acc_ok) begin
         if (!m_in_frame) begin
            m_mode = odd;
            m_ones = 0;
         end
         mode_w = m_mode;
         g = want_par(d, mode_w);
         m_ones += $countones(d);
         werr = chk && (par != g);
         m_valid = 1; m_data = d; m_par = g; m_last = last; m_werr = werr;
         if (last) begin
            m_fpar = bit'((m_ones + (mode_w ? 1 : 0)) % 2);
            m_in_frame = 0;
         end else begin
            m_fpar = 0;
            m_in_frame = 1;
         end
      end else if (ordy) begin
         m_valid = 0;
      end
      if (clr) begin
         m_err  = werr ? 1 : 0;
         m_err2 = werr ? 1 : 0;
      end else if (werr) begin
         if (m_err < 255) m_err++;
         if (m_err2 < 3) m_err2++;
      end
   endtask

   task automatic idle_cycle();
      step(0, '0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_reset();
      checks++;
      if ({out_valid, out_data, out_par, out_last, out_frame_par, out_word_err} !== '0 || err_cnt !== 8'd0) begin
         fails++;
         $display("FAIL reset_state: outputs=%h err_cnt=%0d required all zero", {out_valid, out_data, out_par, out_last, out_frame_par, out_word_err}, err_cnt);
      end
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      // start a frame, then reset asynchronously in mid-cycle
      step(1, 9'h003, 0, 0, 0, 0, 0, 1);
      $display("reset_midframe: accepted 0x003 out_valid=%0b", out_valid);
      #3 rst = 1;
      #1;
      checks++;
      if ({out_valid, out_data, out_par, out_last, out_frame_par, out_word_err} !== '0 || err_cnt !== 8'd0) begin
         fails++;
         $display("FAIL async_reset: outputs=%h err_cnt=%0d required all zero", {out_valid, out_data, out_par, out_last, out_frame_par, out_word_err}, err_cnt);
      end
      #1 rst = 0;
      model_reset();
      @(posedge clk); #1;
      step(1, 9'h001, 0, 1, 0, 0, 0, 1);
      $display("reset_newframe: data=%h frame_par=%0b", out_data, out_frame_par);
      checks++;
      if (out_valid !== 1'b1 || out_frame_par !== 1'b1 || out_par !== 1'b1) begin
         fails++;
         $display("FAIL reset_acc_cleared: valid=%0b frame_par=%0b par=%0b required 1 1 1", out_valid, out_frame_par, out_par);
      end
      idle_cycle();
   endtask

   task automatic test_even_single();
      step(1, 9'h1A5, 0, 1, 0, 0, 0, 1);
      $display("even_single: data=%h par=%0b last=%0b frame_par=%0b", out_data, out_par, out_last, out_frame_par);
      checks++;
      if (out_valid !== 1'b1 || out_par !== 1'b1 || out_frame_par !== 1'b1 || out_last !== 1'b1 || out_data !== 9'h1A5) begin
         fails++;
         $display("FAIL even_single: valid=%0b par=%0b fpar=%0b last=%0b data=%h required 1 1 1 1 1a5", out_valid, out_par, out_frame_par, out_last, out_data);
      end
      idle_cycle();
   endtask

   task automatic test_odd_frame();
      logic [DW-1:0] words [3];
      bit exp_par [3];
      bit exp_fp  [3];
      words[0] = 9'h000; words[1] = 9'h001; words[2] = 9'h1FF;
      exp_par[0] = 1; exp_par[1] = 0; exp_par[2] = 0;
      exp_fp[0]  = 0; exp_fp[1]  = 0; exp_fp[2]  = 1;
      for (int i = 0; i < 3; i++) begin
         step(1, words[i], 0, (i == 2), (i == 0), 0, 0, 1);
         $display("odd_frame word %0d: data=%h par=%0b fpar=%0b last=%0b", i, out_data, out_par, out_frame_par, out_last);
         checks++;
         if (out_par !== exp_par[i] || out_frame_par !== exp_fp[i] || out_data !== words[i]) begin
            fails++;
            $display("FAIL odd_frame_w%0d: par=%0b fpar=%0b data=%h required %0b %0b %h", i, out_par, out_frame_par, out_data, exp_par[i], exp_fp[i], words[i]);
         end
      end
      idle_cycle();
   endtask

   task automatic test_backpressure();
      step(1, 9'h0F0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 9'h111, 0, 1, 0, 0, 0, 0);
         $display("backpressure stall %0d: in_ready=%0b data=%h", i, obs_ready, out_data);
         checks++;
         if (obs_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 9'h0F0 || out_par !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_hold%0d: in_ready=%0b valid=%0b data=%h par=%0b required 0 1 0f0 0", i, obs_ready, out_valid, out_data, out_par);
         end
      end
      step(1, 9'h111, 0, 1, 0, 0, 0, 1);
      $display("backpressure release: data=%h", out_data);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h111 || out_par !== 1'b1) begin
         fails++;
         $display("FAIL backpressure_rel1: valid=%0b data=%h par=%0b required 1 111 1", out_valid, out_data, out_par);
      end
      step(1, 9'h007, 0, 1, 0, 0, 0, 1);
      $display("backpressure next: data=%h", out_data);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h007 || out_par !== 1'b1) begin
         fails++;
         $display("FAIL backpressure_rel2: valid=%0b data=%h par=%0b required 1 007 1", out_valid, out_data, out_par);
      end
      idle_cycle();
      checks++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL backpressure_drain: valid=%0b required 0", out_valid);
      end
   endtask

   task automatic test_checking();
      logic [DW-1:0] d;
      bit bad, par;
      step(0, '0, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) begin
         d = DW'($urandom);
         bad = (i == 1) || (i == 3);
         par = want_par(d, 0) ^ bad;
         step(1, d, par, (i == 3), 0, 1, 0, 1);
         $display("checking word %0d: data=%h word_err=%0b err_cnt=%0d", i, out_data, out_word_err, err_cnt);
         checks++;
         if (out_word_err !== bad) begin
            fails++;
            $display("FAIL check_word_err%0d: got %0b required %0b", i, out_word_err, bad);
         end
      end
      checks++;
      if (err_cnt !== 8'd2) begin
         fails++;
         $display("FAIL check_err_cnt: got %0d required 2", err_cnt);
      end
      d = 9'h0AA;
      step(1, d, ~want_par(d, 0), 1, 0, 1, 1, 1);
      $display("checking clear+error: err_cnt=%0d", err_cnt);
      checks++;
      if (err_cnt !== 8'd1) begin
         fails++;
         $display("FAIL check_clr_with_err: got %0d required 1", err_cnt);
      end
      idle_cycle();
   endtask

   task automatic test_saturation();
      int exp2 [5];
      logic [DW-1:0] d;
      exp2[0] = 1; exp2[1] = 2; exp2[2] = 3; exp2[3] = 3; exp2[4] = 3;
      step(0, '0, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 5; i++) begin
         d = DW'($urandom);
         step(1, d, ~want_par(d, 0), 1, 0, 1, 0, 1);
         $display("saturation word %0d: err_cnt(8b)=%0d err_cnt(2b)=%0d", i, err_cnt, err_cnt2);
         checks++;
         if (int'(err_cnt2) != exp2[i] || int'(err_cnt) != i + 1) begin
            fails++;
            $display("FAIL saturation%0d: cnt2=%0d cnt8=%0d required %0d %0d", i, err_cnt2, err_cnt, exp2[i], i + 1);
         end
      end
      idle_cycle();
   endtask

   task automatic test_random();
      logic [DW-1:0] d;
      bit v, last, odd, chk, clr, ordy, par;
      for (int n = 0; n < 400; n++) begin
         v    = ($urandom_range(0, 3) != 0);
         d    = DW'($urandom);
         last = ($urandom_range(0, 3) == 0);
         odd  = $urandom_range(0, 1) != 0;
         chk  = ($urandom_range(0, 1) != 0);
         clr  = ($urandom_range(0, 15) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         par  = $urandom_range(0, 1) != 0;
         step(v, d, par, last, odd, chk, clr, ordy);
         $display("random %0d: v=%0b rdy=%0b out_valid=%0b data=%h par=%0b last=%0b fpar=%0b werr=%0b cnt=%0d cnt2=%0d",
                  n, v, obs_ready, out_valid, out_data, out_par, out_last, out_frame_par, out_word_err, err_cnt, err_cnt2);
         checks++;
         if (obs_ready !== m_rdy || out_valid !== m_valid || int'(err_cnt) != m_err || int'(err_cnt2) != m_err2 ||
             (m_valid && (out_data !== m_data || out_par !== m_par || out_last !== m_last ||
                          out_frame_par !== m_fpar || out_word_err !== m_werr))) begin
            fails++;
            $display("FAIL random%0d: rdy=%0b valid=%0b data=%h par=%0b last=%0b fpar=%0b werr=%0b cnt=%0d cnt2=%0d required %0b %0b %h %0b %0b %0b %0b %0d %0d",
                     n, obs_ready, out_valid, out_data, out_par, out_last, out_frame_par, out_word_err, err_cnt, err_cnt2,
                     m_rdy, m_valid, m_data, m_par, m_last, m_fpar, m_werr, m_err, m_err2);
         end
      end
   endtask

   initial begin
      model_reset();
      #2;
      test_reset();
      test_even_single();
      test_odd_frame();
      test_backpressure();
      test_checking();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule : tb_parity_stream_gen_chk

// File: doc/parity_stream_gen_chk.md
Name: parity_stream_gen_chk

Overview:
Streaming, parametrised successor to the 9-bit even/odd parity generator. Accepts data words over a valid/ready handshake and produces a registered per-word parity bit in a selectable even/odd mode. Also accumulates a running parity over multi-word frames and optionally checks a received parity bit, keeping a saturating error count. Sits between a word source and a link/serializer stage.

Parameters:
DATA_W, 9, data word width (>=1)
CNT_W, 8, width of the saturating error counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  input word present
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  data word
in_par  input  1  received parity bit; compared only when chk_en=1
in_last  input  1  word is the last of its frame
odd_sel  input  1  0 = even parity, 1 = odd parity; sampled at frame start
chk_en  input  1  enable parity checking of in_par
err_clr  input  1  synchronous clear of err_cnt
out_valid  output  1  output word present
out_ready  input  1  downstream accepts output
out_data  output  DATA_W  registered copy of in_data
out_par  output  1  generated word parity
out_last  output  1  registered in_last
out_frame_par  output  1  frame parity; meaningful only when out_last=1
out_word_err  output  1  in_par mismatched generated parity (0 when chk_en was 0)
err_cnt  output  CNT_W  saturating count of mismatches

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_par=0, out_last=0, out_frame_par=0, out_word_err=0, err_cnt=0, frame accumulator acc=0, latched mode=0, FSM=IDLE. An in-flight frame is discarded. The first word accepted after reset starts a new frame.
- Handshake: accept = in_valid & in_ready. in_ready = ~out_valid | out_ready, a single output register. Output is held stable while out_valid & ~out_ready. Latency is 1 cycle from accept to out_valid. Full throughput of 1 word/cycle under continuous out_ready.
- Word parity: p = XOR of all DATA_W bits of in_data. Generated parity g = p ^ mode. In even mode, data plus g has an even number of ones. In odd mode, data plus g has an odd number of ones.
- Mode: in IDLE, an accepted word latches mode = odd_sel and uses odd_sel directly. In IN_FRAME, the latched mode is used and odd_sel is ignored.
- FSM:
  - IDLE, accept with ~in_last -> IN_FRAME.
  - IDLE, accept with in_last -> IDLE (single-word frame).
  - IN_FRAME, accept with in_last -> IDLE.
  - IN_FRAME, accept with ~in_last -> stay.
  - No accept -> no change.
- Accumulator: on accept with ~in_last, acc <= acc ^ p (acc is treated as 0 when in IDLE). On accept with in_last, out_frame_par <= acc ^ p ^ mode and acc <= 0. out_frame_par is 0 on non-last words.
- Check: out_word_err <= chk_en & (in_par != g), registered with the word. err_cnt increments by 1 on each accepted erroring word. err_cnt saturates at 2^CNT_W-1 and never wraps.
- err_clr: err_cnt <= 0, or <= 1 if an erroring word is accepted in the same cycle, so the error is not lost. err_clr does not affect the datapath.
- Backpressure never changes acc, FSM, or err_cnt. Only accepted words do.

Decomposition:
- Shared package parity_pkg holds the FSM state encoding (ST_IDLE=1'b0, ST_IN_FRAME=1'b1) and the mode constants PAR_EVEN=0, PAR_ODD=1.
- One sub-module, parity_reduce (parameter DATA_W; combinational XOR reduction in_data -> p), instantiated once.
- Handshake, FSM, accumulator and counter all live in the top module.

Test Plan:
- Reset mid-frame: accept 9'h003 (~in_last), then pulse rst asynchronously -> all outputs 0, err_cnt=0. Next word 9'h001 with in_last and odd_sel=0 yields out_frame_par=1, confirming acc was cleared.
- Even single-word frame: odd_sel=0, in_data=9'h1A5 (5 ones), in_last=1 -> one cycle later out_valid=1, out_par=1, out_frame_par=1, out_last=1.
- Odd 3-word frame: odd_sel=1 at first word, words 9'h000, 9'h001, 9'h1FF, with odd_sel driven 0 on words 2-3 -> out_par=1,0,0 and out_frame_par=1 on the third word (mode held).
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data/out_par unchanged, no extra word accepted. Release yields one word per cycle with no loss or duplication.
- Checking: chk_en=1, even mode, 4 words with in_par wrong on words 2 and 4 -> out_word_err pulses on those outputs, err_cnt=2. Then err_clr asserted on a cycle accepting an erroring word -> err_cnt=1.
- Saturation: CNT_W=2, 5 erroring words accepted -> err_cnt sequence 1,2,3,3,3.
